// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter
// Purpose  : Two-requester arbiter (instruction fetch / data access) for a
//            single registered sys_bus port. MEM normally has priority, but
//            IF wins once after a run of contested MEM grants. Each bus access
//            is guarded by a timeout.
// Revision : 1.0 - initial release
// ============================================================================
module bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned MAX_MEM_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req,
    input  logic [63:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,

    input  logic        mem_req,
    input  logic [63:0] mem_addr,
    input  logic [63:0] mem_wdata,
    input  logic [2:0]  mem_rd_ctrl,
    input  logic [2:0]  mem_wr_ctrl,
    output logic [63:0] mem_rdata,
    output logic        mem_ack,

    output logic [63:0] bus_addr,
    output logic [63:0] bus_din,
    output logic [2:0]  bus_rd_ctrl,
    output logic [2:0]  bus_wr_ctrl,
    input  logic [63:0] bus_dout,
    input  logic        bus_ready,

    output logic        grant_mem,
    output logic        bus_err
);

    localparam int CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int STREAK_W = $clog2(MAX_MEM_STREAK + 1);

    localparam logic [CNT_W-1:0]    c_timeout_last = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [STREAK_W-1:0] c_streak_max   = STREAK_W'(MAX_MEM_STREAK);

    // Fetch is a 32-bit word read, zero-extended
    localparam logic [2:0] c_if_rd_ctrl = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_BUSY_IF  = 2'd1,
        S_BUSY_MEM = 2'd2
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_timeout;
    logic [STREAK_W-1:0] r_streak;

    logic w_if_elig;
    logic w_mem_elig;
    logic w_streak_full;
    logic w_pick_if;
    logic w_pick_mem;
    logic w_done;

    // A request whose ack is high this cycle is the one just served; it must
    // not be granted again off the same (still asserted) req level.
    assign w_if_elig     = if_req  & ~if_ack;
    assign w_mem_elig    = mem_req & ~mem_ack;
    assign w_streak_full = (r_streak == c_streak_max);
    assign w_pick_if     = w_if_elig & (~w_mem_elig | w_streak_full);
    assign w_pick_mem    = w_mem_elig & ~w_pick_if;
    assign w_done        = bus_ready | (r_timeout == c_timeout_last);

    // Arbitration FSM with registered bus, ack and error outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_timeout   <= '0;
            r_streak    <= '0;
            if_rdata    <= '0;
            if_ack      <= 1'b0;
            mem_rdata   <= '0;
            mem_ack     <= 1'b0;
            bus_addr    <= '0;
            bus_din     <= '0;
            bus_rd_ctrl <= '0;
            bus_wr_ctrl <= '0;
            grant_mem   <= 1'b0;
            bus_err     <= 1'b0;
        end else begin
            if_ack  <= 1'b0;
            mem_ack <= 1'b0;
            bus_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_timeout <= '0;
                    if (w_pick_if) begin
                        r_state     <= S_BUSY_IF;
                        r_streak    <= '0;
                        bus_addr    <= if_addr;
                        bus_din     <= '0;
                        bus_rd_ctrl <= c_if_rd_ctrl;
                        bus_wr_ctrl <= '0;
                        grant_mem   <= 1'b0;
                    end else if (w_pick_mem) begin
                        r_state     <= S_BUSY_MEM;
                        // Only grants that actually beat a waiting fetch count
                        if (w_if_elig && !w_streak_full) begin
                            r_streak <= r_streak + STREAK_W'(1);
                        end
                        bus_addr    <= mem_addr;
                        bus_din     <= mem_wdata;
                        bus_rd_ctrl <= mem_rd_ctrl;
                        bus_wr_ctrl <= mem_wr_ctrl;
                        grant_mem   <= 1'b1;
                    end
                end
                S_BUSY_IF, S_BUSY_MEM: begin
                    if (w_done) begin
                        // bus_ready wins over a simultaneous timeout
                        if (r_state == S_BUSY_IF) begin
                            if_ack   <= 1'b1;
                            if_rdata <= bus_ready ? bus_dout[31:0] : 32'd0;
                        end else begin
                            mem_ack   <= 1'b1;
                            mem_rdata <= bus_ready ? bus_dout : 64'd0;
                        end
                        bus_err     <= ~bus_ready;
                        r_state     <= S_IDLE;
                        r_timeout   <= '0;
                        bus_addr    <= '0;
                        bus_din     <= '0;
                        bus_rd_ctrl <= '0;
                        bus_wr_ctrl <= '0;
                        grant_mem   <= 1'b0;
                    end else begin
                        r_timeout <= r_timeout + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_arbiter
// Purpose  : Self-checking bench for bus_arbiter: transaction-level reference
//            model compared every cycle, directed scenarios with literal
//            expectations, and randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

    localparam int TO = 16;
    localparam int MS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [63:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [2:0]  mem_rd_ctrl;
    logic [2:0]  mem_wr_ctrl;
    logic [63:0] mem_rdata;
    logic        mem_ack;
    logic [63:0] bus_addr;
    logic [63:0] bus_din;
    logic [2:0]  bus_rd_ctrl;
    logic [2:0]  bus_wr_ctrl;
    logic [63:0] bus_dout;
    logic        bus_ready;
    logic        grant_mem;
    logic        bus_err;

    always #5 clk = ~clk;

    bus_arbiter #(
        .TIMEOUT_CYCLES (TO),
        .MAX_MEM_STREAK (MS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_rdata    (if_rdata),
        .if_ack      (if_ack),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rd_ctrl (mem_rd_ctrl),
        .mem_wr_ctrl (mem_wr_ctrl),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .bus_addr    (bus_addr),
        .bus_din     (bus_din),
        .bus_rd_ctrl (bus_rd_ctrl),
        .bus_wr_ctrl (bus_wr_ctrl),
        .bus_dout    (bus_dout),
        .bus_ready   (bus_ready),
        .grant_mem   (grant_mem),
        .bus_err     (bus_err)
    );

    int n_vec = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    // owner: 0 = nobody on the bus, 1 = fetch, 2 = data access
    int          owner   = 0;
    int          elapsed = 0;   // cycles the current access has been on the bus
    int          streak  = 0;   // contested MEM wins since the last IF grant
    logic [63:0] e_bus_addr = '0, e_bus_din = '0, e_mem_rdata = '0;
    logic [31:0] e_if_rdata = '0;
    logic [2:0]  e_rd = '0, e_wr = '0;
    logic        e_if_ack = 1'b0, e_mem_ack = 1'b0, e_grant_mem = 1'b0, e_bus_err = 1'b0;

    task automatic model_edge();
        logic        if_el, mem_el;
        logic [63:0] data;
        if (!rst) begin
            owner = 0; elapsed = 0; streak = 0;
            e_bus_addr = '0; e_bus_din = '0; e_rd = '0; e_wr = '0;
            e_if_rdata = '0; e_mem_rdata = '0;
            e_if_ack = 1'b0; e_mem_ack = 1'b0; e_grant_mem = 1'b0; e_bus_err = 1'b0;
        end else begin
            if_el  = if_req  && !e_if_ack;
            mem_el = mem_req && !e_mem_ack;
            e_if_ack = 1'b0; e_mem_ack = 1'b0; e_bus_err = 1'b0;
            if (owner == 0) begin
                if (if_el && (!mem_el || streak == MS)) begin
                    owner = 1; elapsed = 0; streak = 0;
                    e_bus_addr = if_addr; e_bus_din = '0; e_rd = 3'd5; e_wr = '0;
                    e_grant_mem = 1'b0;
                end else if (mem_el) begin
                    owner = 2; elapsed = 0;
                    if (if_el && streak < MS) streak++;
                    e_bus_addr = mem_addr; e_bus_din = mem_wdata;
                    e_rd = mem_rd_ctrl; e_wr = mem_wr_ctrl;
                    e_grant_mem = 1'b1;
                end
            end else begin
                if (bus_ready || elapsed == TO - 1) begin
                    data      = bus_ready ? bus_dout : 64'd0;
                    e_bus_err = !bus_ready;
                    if (owner == 1) begin
                        e_if_ack = 1'b1; e_if_rdata = data[31:0];
                    end else begin
                        e_mem_ack = 1'b1; e_mem_rdata = data;
                    end
                    owner = 0;
                    e_bus_addr = '0; e_bus_din = '0; e_rd = '0; e_wr = '0;
                    e_grant_mem = 1'b0;
                end else begin
                    elapsed++;
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("bus_addr",    bus_addr,    e_bus_addr);
        check("bus_din",     bus_din,     e_bus_din);
        check("bus_rd_ctrl", 64'(bus_rd_ctrl), 64'(e_rd));
        check("bus_wr_ctrl", 64'(bus_wr_ctrl), 64'(e_wr));
        check("if_ack",      64'(if_ack),    64'(e_if_ack));
        check("if_rdata",    64'(if_rdata),  64'(e_if_rdata));
        check("mem_ack",     64'(mem_ack),   64'(e_mem_ack));
        check("mem_rdata",   mem_rdata,      e_mem_rdata);
        check("grant_mem",   64'(grant_mem), 64'(e_grant_mem));
        check("bus_err",     64'(bus_err),   64'(e_bus_err));
        check("acks_exclusive", 64'(if_ack & mem_ack), 64'd0);
    endtask

    // One clock: model advances on the same edge as the DUT, compare 1ns later
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic quiet_inputs();
        if_req = 1'b0; if_addr = '0;
        mem_req = 1'b0; mem_addr = '0; mem_wdata = '0;
        mem_rd_ctrl = '0; mem_wr_ctrl = '0;
        bus_dout = '0; bus_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    int rdy_pct [4] = '{60, 5, 30, 3};
    int req_pct [4] = '{75, 75, 50, 50};

    initial begin
        quiet_inputs();
        do_reset();
        check("reset_bus_rd_ctrl", 64'(bus_rd_ctrl), 64'd0);
        check("reset_grant_mem",   64'(grant_mem),   64'd0);

        // Single fetch, minimum latency
        if_req = 1'b1; if_addr = 64'h1000; bus_dout = 64'h13;
        step();
        check("fetch_rd_ctrl", 64'(bus_rd_ctrl), 64'd5);
        check("fetch_addr",    bus_addr,         64'h1000);
        bus_ready = 1'b1;
        step();
        check("fetch_ack",   64'(if_ack),   64'd1);
        check("fetch_rdata", 64'(if_rdata), 64'h13);
        check("fetch_idle_rd_ctrl", 64'(bus_rd_ctrl), 64'd0);
        quiet_inputs();
        step();

        // Simultaneous store and fetch: MEM first, then IF
        do_reset();
        if_req = 1'b1; if_addr = 64'h3000;
        mem_req = 1'b1; mem_addr = 64'h2000; mem_wdata = 64'hDEAD; mem_wr_ctrl = 3'd3;
        step();
        check("both_grant_mem", 64'(grant_mem),   64'd1);
        check("both_bus_din",   bus_din,          64'hDEAD);
        check("both_wr_ctrl",   64'(bus_wr_ctrl), 64'd3);
        bus_ready = 1'b1;
        step();
        check("both_mem_ack", 64'(mem_ack), 64'd1);
        check("both_if_wait", 64'(if_ack),  64'd0);
        mem_req = 1'b0;
        step();
        check("both_if_grant", 64'(bus_rd_ctrl), 64'd5);
        check("both_if_addr",  bus_addr,         64'h3000);
        step();
        check("both_if_ack",  64'(if_ack),  64'd1);
        check("both_mem_off", 64'(mem_ack), 64'd0);
        quiet_inputs();
        step();

        // Streak: after MS contested MEM wins the next contest goes to IF
        do_reset();
        for (int k = 1; k <= MS + 1; k++) begin
            if_req = 1'b1; mem_req = 1'b1; mem_addr = 64'(k); bus_ready = 1'b0;
            step();
            check("streak_grant_mem", 64'(grant_mem), (k <= MS) ? 64'd1 : 64'd0);
            if_req = 1'b0; bus_ready = 1'b1;
            step();
            mem_req = 1'b0; bus_ready = 1'b0;
            step();
        end
        quiet_inputs();

        // Timeout on a load
        do_reset();
        mem_req = 1'b1; mem_rd_ctrl = 3'd3; mem_addr = 64'h40;
        step();
        for (int i = 0; i < TO - 1; i++) step();
        check("to_ack_not_yet", 64'(mem_ack), 64'd0);
        step();
        check("to_mem_ack",   64'(mem_ack),   64'd1);
        check("to_mem_rdata", mem_rdata,      64'd0);
        check("to_bus_err",   64'(bus_err),   64'd1);
        mem_req = 1'b0;
        step();
        check("to_err_pulse", 64'(bus_err), 64'd0);

        // bus_ready on the last allowed cycle completes normally
        mem_req = 1'b1; bus_dout = 64'h55;
        step();
        for (int i = 0; i < TO - 1; i++) step();
        bus_ready = 1'b1;
        step();
        check("lastcyc_mem_ack",   64'(mem_ack), 64'd1);
        check("lastcyc_mem_rdata", mem_rdata,    64'h55);
        check("lastcyc_no_err",    64'(bus_err), 64'd0);
        quiet_inputs();
        step();

        // Reset in the middle of a fetch drops it; held request re-granted
        if_req = 1'b1; if_addr = 64'h8000;
        step();
        step();
        rst = 1'b0;
        step();
        check("midrst_rd_ctrl", 64'(bus_rd_ctrl), 64'd0);
        check("midrst_if_ack",  64'(if_ack),      64'd0);
        check("midrst_addr",    bus_addr,         64'd0);
        rst = 1'b1;
        step();
        check("postrst_regrant", 64'(bus_rd_ctrl), 64'd5);
        check("postrst_addr",    bus_addr,         64'h8000);
        quiet_inputs();
        step();

        // Randomized traffic in phases of differing bus speed and load
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < 800; c++) begin
                rst         = ($urandom_range(0, 299) != 0);
                if_req      = ($urandom_range(0, 99) < req_pct[p]);
                if_addr     = {$urandom(), $urandom()};
                mem_req     = ($urandom_range(0, 99) < req_pct[p]);
                mem_addr    = {$urandom(), $urandom()};
                mem_wdata   = {$urandom(), $urandom()};
                mem_rd_ctrl = 3'($urandom_range(0, 7));
                mem_wr_ctrl = 3'($urandom_range(0, 7));
                bus_dout    = {$urandom(), $urandom()};
                bus_ready   = ($urandom_range(0, 99) < rdy_pct[p]);
                step();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16, max BUSY cycles before abort (>=2).
REQ-002 Parameter: MAX_MEM_STREAK, default 4, consecutive contested MEM grants before IF wins once (>=1).
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset; one clock; reset is synchronous and active-low.
REQ-005 if_req  in  1  instruction-fetch request, held until if_ack.
REQ-006 if_addr  in  64  fetch address.
REQ-007 if_rdata  out  32  fetched instruction, valid while if_ack=1.
REQ-008 if_ack  out  1  one-cycle fetch completion pulse.
REQ-009 mem_req  in  1  data-access request, held until mem_ack.
REQ-010 mem_addr  in  64  data address.
REQ-011 mem_wdata  in  64  store data.
REQ-012 mem_rd_ctrl  in  3  load type; 0 = no read.
REQ-013 mem_wr_ctrl  in  3  store type; 0 = no write.
REQ-014 mem_rdata  out  64  load data, valid while mem_ack=1.
REQ-015 mem_ack  out  1  one-cycle data completion pulse.
REQ-016 bus_addr  out  64  sys_bus address, registered.
REQ-017 bus_din  out  64  sys_bus write data, registered.
REQ-018 bus_rd_ctrl  out  3  sys_bus read control, registered.
REQ-019 bus_wr_ctrl  out  3  sys_bus write control, registered.
REQ-020 bus_dout  in  64  sys_bus read data.
REQ-021 bus_ready  in  1  sys_bus completion, sampled only in BUSY states.
REQ-022 grant_mem  out  1  high in BUSY_MEM; pipeline stall source for IF.
REQ-023 bus_err  out  1  one-cycle pulse on timeout abort.

Function
REQ-024 States: IDLE, BUSY_IF, BUSY_MEM; 2-bit encoded, registered.
REQ-025 IDLE, no eligible request: bus_addr/bus_din 0, bus_rd_ctrl 0, bus_wr_ctrl 0.
REQ-026 Eligible: req=1 and that requester's ack not high this cycle (blocks re-grant of a just-acked request).
REQ-027 IDLE, only one eligible: grant it at next edge.
REQ-028 IDLE, both eligible: MEM wins unless mem_streak == MAX_MEM_STREAK, then IF wins.
REQ-029 mem_streak increments (saturating) on each MEM grant while IF also eligible; clears on any IF grant.
REQ-030 IF grant: bus_addr<=if_addr, bus_rd_ctrl<=3'b101 (word, zero-ext), bus_wr_ctrl<=0, bus_din<=0; state<=BUSY_IF.
REQ-031 MEM grant: bus_addr<=mem_addr, bus_din<=mem_wdata, bus_rd_ctrl<=mem_rd_ctrl, bus_wr_ctrl<=mem_wr_ctrl; state<=BUSY_MEM.
REQ-032 BUSY: bus outputs held constant; timeout counter increments per cycle from 0.
REQ-033 BUSY, bus_ready=1: at edge, capture bus_dout (if_rdata<=bus_dout[31:0] or mem_rdata<=bus_dout), pulse owner's ack, bus outputs to 0, state<=IDLE.
REQ-034 Minimum latency: req in IDLE cycle N, bus_ready=1 in cycle N+1 -> ack in cycle N+2.
REQ-035 BUSY, counter == TIMEOUT_CYCLES-1 and bus_ready=0: pulse owner's ack with rdata 0, pulse bus_err, state<=IDLE.
REQ-036 bus_ready on the timeout cycle takes precedence: normal completion, no bus_err.
REQ-037 Requests arriving during BUSY wait; never preempt. if_ack and mem_ack never high together.
REQ-038 rdata registers hold last value between acks (except timeout zeroing).

Reset
REQ-039 rst=0 at edge: state IDLE, all outputs 0, mem_streak 0, timeout counter 0; applies mid-transaction, in-flight access dropped with no ack.
REQ-040 First arbitration occurs in the first cycle with rst=1.

Verification
REQ-041 if_req=1 alone, if_addr=0x1000, bus_ready=1 one cycle after grant, bus_dout=0x00000013 -> bus_rd_ctrl=5 one cycle, if_ack pulse with if_rdata=0x13 two cycles after request.
REQ-042 if_req and mem_req (store, wr_ctrl=3, addr 0x2000, wdata 0xDEAD) same cycle -> MEM served first, bus_din=0xDEAD, then IF; acks never overlap.
REQ-043 mem_req and if_req both held continuously, MAX_MEM_STREAK=4 -> grant sequence MEM,MEM,MEM,MEM,IF,MEM...
REQ-044 BUSY_MEM, bus_ready held 0 -> after 16 cycles mem_ack=1, mem_rdata=0, bus_err=1 one cycle, state IDLE; variant with bus_ready=1 on cycle 16 -> no bus_err.
REQ-045 rst=0 during BUSY_IF -> next cycle all outputs 0, no if_ack; after rst=1, held if_req re-granted.
